// File: rtl/alarm_sequencer.sv
// Alarm sequencer: IDLE -> RING -> SNOOZE state machine with half-second timebase.
// Define ALARM_CADENCE_EN to pulse ring_on 0.5 s on / 0.5 s off while ringing.
module alarm_sequencer #(
    parameter int TICKS_PER_SEC  = 50000000,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alarm_enable,
    input  logic       alarm_match,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       ring_on,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_t;

    localparam int HALF_TICKS    = TICKS_PER_SEC / 2;
    localparam int PRE_W         = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
    localparam int RING_HALVES   = 2 * RING_TIMEOUT_S;
    localparam int SNOOZE_HALVES = 2 * SNOOZE_S;
    localparam int MAX_HALVES    = (RING_HALVES > SNOOZE_HALVES) ? RING_HALVES : SNOOZE_HALVES;
    localparam int HALF_W        = $clog2(MAX_HALVES + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(HALF_TICKS - 1);
    localparam logic [HALF_W-1:0] RING_LAST   = HALF_W'(RING_HALVES - 1);
    localparam logic [HALF_W-1:0] SNOOZE_LAST = HALF_W'(SNOOZE_HALVES - 1);
    localparam logic [1:0]        MAX_CNT     = 2'(MAX_SNOOZES);

    state_t              state_q;
    logic [PRE_W-1:0]    pre_cnt;
    logic [HALF_W-1:0]   half_cnt;
    logic                match_q;
    logic                snooze_q;
    logic                stop_q;

    logic                match_ev;
    logic                snooze_ev;
    logic                stop_ev;
    logic                half_tick;
    logic                ring_done;
    logic                snooze_done;
    logic                can_snooze;
    logic [PRE_W-1:0]    pre_next;
    logic [HALF_W-1:0]   half_next;

    assign state = state_q;

    assign match_ev  = alarm_match & ~match_q;
    assign snooze_ev = snooze_btn  & ~snooze_q;
    assign stop_ev   = stop_btn    & ~stop_q;

    // The timeout compares fire on the last prescaler tick of the last half-second,
    // so the state changes exactly N half-seconds after entry.
    assign half_tick   = (pre_cnt == PRE_LAST);
    assign ring_done   = half_tick && (half_cnt == RING_LAST);
    assign snooze_done = half_tick && (half_cnt == SNOOZE_LAST);
    assign can_snooze  = (snooze_cnt < MAX_CNT);

    assign pre_next  = half_tick ? '0 : pre_cnt + 1'b1;
    assign half_next = half_tick ? half_cnt + 1'b1 : half_cnt;

    // Edge-detect flops reset high so inputs already asserted at release are not events.
    // Priority inside the FSM: disable, then stop, then snooze, then timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ring_on    <= 1'b0;
            snooze_cnt <= 2'd0;
            pre_cnt    <= '0;
            half_cnt   <= '0;
            match_q    <= 1'b1;
            snooze_q   <= 1'b1;
            stop_q     <= 1'b1;
        end else begin
            match_q  <= alarm_match;
            snooze_q <= snooze_btn;
            stop_q   <= stop_btn;

            if (!alarm_enable) begin
                state_q    <= IDLE;
                ring_on    <= 1'b0;
                snooze_cnt <= 2'd0;
                pre_cnt    <= '0;
                half_cnt   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (match_ev) begin
                            state_q  <= RING;
                            ring_on  <= 1'b1;
                            pre_cnt  <= '0;
                            half_cnt <= '0;
                        end
                    end

                    RING: begin
                        if (stop_ev || (!(snooze_ev && can_snooze) && ring_done)) begin
                            state_q    <= IDLE;
                            ring_on    <= 1'b0;
                            snooze_cnt <= 2'd0;
                            pre_cnt    <= '0;
                            half_cnt   <= '0;
                        end else if (snooze_ev && can_snooze) begin
                            state_q    <= SNOOZE;
                            ring_on    <= 1'b0;
                            snooze_cnt <= snooze_cnt + 2'd1;
                            pre_cnt    <= '0;
                            half_cnt   <= '0;
                        end else begin
                            pre_cnt  <= pre_next;
                            half_cnt <= half_next;
`ifdef ALARM_CADENCE_EN
                            if (half_tick) begin
                                ring_on <= ~ring_on;
                            end
`else
                            ring_on <= 1'b1;
`endif
                        end
                    end

                    SNOOZE: begin
                        if (stop_ev) begin
                            state_q    <= IDLE;
                            ring_on    <= 1'b0;
                            snooze_cnt <= 2'd0;
                            pre_cnt    <= '0;
                            half_cnt   <= '0;
                        end else if (snooze_done) begin
                            state_q  <= RING;
                            ring_on  <= 1'b1;
                            pre_cnt  <= '0;
                            half_cnt <= '0;
                        end else begin
                            ring_on  <= 1'b0;
                            pre_cnt  <= pre_next;
                            half_cnt <= half_next;
                        end
                    end

                    default: begin
                        state_q    <= IDLE;
                        ring_on    <= 1'b0;
                        snooze_cnt <= 2'd0;
                        pre_cnt    <= '0;
                        half_cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: elapsed-cycle reference model compared every cycle,
// plus directed literal checks. Honours ALARM_CADENCE_EN like the design.
module tb_alarm_sequencer;

    localparam int TPS      = 10;
    localparam int RING_S   = 2;
    localparam int SNZ_S    = 1;
    localparam int MAXS     = 2;
    localparam int HALF     = TPS / 2;
    localparam int RING_LIM = 2 * RING_S * HALF;
    localparam int SNZ_LIM  = 2 * SNZ_S * HALF;
`ifdef ALARM_CADENCE_EN
    localparam bit CAD = 1'b1;
`else
    localparam bit CAD = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       alarm_enable;
    logic       alarm_match;
    logic       snooze_btn;
    logic       stop_btn;
    logic       ring_on;
    logic [1:0] state;
    logic [1:0] snooze_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    alarm_sequencer #(
        .TICKS_PER_SEC (TPS),
        .RING_TIMEOUT_S(RING_S),
        .SNOOZE_S      (SNZ_S),
        .MAX_SNOOZES   (MAXS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alarm_enable(alarm_enable),
        .alarm_match (alarm_match),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .ring_on     (ring_on),
        .state       (state),
        .snooze_cnt  (snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one elapsed-cycle count per visit to RING/SNOOZE.
    int m_state = 0;
    bit m_ring  = 1'b0;
    int m_cnt   = 0;
    int m_el    = 0;
    bit pm = 1'b1, ps = 1'b1, pt = 1'b1;

    always @(posedge clk) begin
        bit me, se, te;
        if (reset) begin
            m_state = 0; m_ring = 1'b0; m_cnt = 0; m_el = 0;
            pm = 1'b1; ps = 1'b1; pt = 1'b1;
        end else begin
            me = alarm_match && !pm;
            se = snooze_btn && !ps;
            te = stop_btn && !pt;
            pm = alarm_match; ps = snooze_btn; pt = stop_btn;
            if (!alarm_enable || (m_state != 0 && te)) begin
                m_state = 0; m_ring = 1'b0; m_cnt = 0; m_el = 0;
            end else if (m_state == 0) begin
                if (me) begin m_state = 1; m_ring = 1'b1; m_el = 0; end
            end else if (m_state == 1) begin
                if (se && m_cnt < MAXS) begin
                    m_state = 2; m_ring = 1'b0; m_cnt++; m_el = 0;
                end else if (m_el + 1 == RING_LIM) begin
                    m_state = 0; m_ring = 1'b0; m_cnt = 0; m_el = 0;
                end else begin
                    m_el++;
                    m_ring = CAD ? (((m_el / HALF) % 2) == 0) : 1'b1;
                end
            end else begin
                if (m_el + 1 == SNZ_LIM) begin
                    m_state = 1; m_ring = 1'b1; m_el = 0;
                end else begin
                    m_el++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (state !== 2'(m_state) || ring_on !== m_ring || snooze_cnt !== 2'(m_cnt)) begin
                failures++;
                $display("[TB] FAIL model_cmp t=%0t state=%0d exp=%0d ring_on=%0b exp=%0b snooze_cnt=%0d exp=%0d",
                         $time, state, m_state, ring_on, m_ring, snooze_cnt, m_cnt);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic en, input logic m,
                                 input logic sn, input logic st, input int n);
        reset = rst; alarm_enable = en; alarm_match = m; snooze_btn = sn; stop_btn = st;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int exp_state,
                               input logic exp_ring, input int exp_cnt);
        checks++;
        if (state !== 2'(exp_state) || ring_on !== exp_ring || snooze_cnt !== 2'(exp_cnt)) begin
            failures++;
            $display("[TB] FAIL %s state=%0d exp=%0d ring_on=%0b exp=%0b snooze_cnt=%0d exp=%0d",
                     name, state, exp_state, ring_on, exp_ring, snooze_cnt, exp_cnt);
        end
    endtask

    initial begin
        reset = 1'b1; alarm_enable = 1'b1; alarm_match = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        applyStimulus(1, 1, 0, 0, 0, 2);
        checkOutput("reset", 0, 1'b0, 0);

        applyStimulus(0, 1, 0, 0, 0, 2);
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("ring_entry", 1, 1'b1, 0);
        applyStimulus(0, 1, 0, 0, 0, 19);
        checkOutput("pre_timeout", 1, CAD ? 1'b0 : 1'b1, 0);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("timeout", 0, 1'b0, 0);

        applyStimulus(0, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 0, 1);
        checkOutput("snooze1", 2, 1'b0, 1);
        applyStimulus(0, 1, 0, 0, 0, 9);
        checkOutput("snooze_hold", 2, 1'b0, 1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("snooze_wake", 1, 1'b1, 1);

        applyStimulus(0, 1, 0, 1, 0, 1);
        applyStimulus(0, 1, 0, 0, 0, 10);
        checkOutput("wake2", 1, 1'b1, 2);
        applyStimulus(0, 1, 0, 1, 0, 1);
        checkOutput("snooze_max", 1, 1'b1, 2);

        applyStimulus(0, 1, 0, 0, 1, 1);
        checkOutput("stop_ring", 0, 1'b0, 0);

        applyStimulus(0, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 0, 1, 1, 1);
        checkOutput("stop_over_snooze", 0, 1'b0, 0);

        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("ring_again", 1, 1'b1, 0);
        applyStimulus(0, 1, 0, 0, 0, 19);
        applyStimulus(0, 1, 0, 1, 0, 1);
        checkOutput("snooze_at_timeout", 2, 1'b0, 1);

        applyStimulus(0, 1, 0, 0, 1, 1);
        checkOutput("stop_snooze", 0, 1'b0, 0);

        applyStimulus(0, 1, 0, 1, 0, 1);
        checkOutput("idle_btn", 0, 1'b0, 0);

        applyStimulus(0, 1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("disable", 0, 1'b0, 0);
        applyStimulus(0, 0, 1, 0, 0, 1);
        checkOutput("match_disabled", 0, 1'b0, 0);
        applyStimulus(0, 1, 1, 0, 0, 2);
        checkOutput("enable_held_match", 0, 1'b0, 0);

        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 1);
        applyStimulus(0, 1, 1, 1, 0, 1);
        checkOutput("pre_reset_snooze", 2, 1'b0, 1);
        applyStimulus(0, 1, 1, 0, 0, 3);
        applyStimulus(1, 1, 1, 0, 0, 1);
        checkOutput("reset_mid_snooze", 0, 1'b0, 0);
        applyStimulus(0, 1, 1, 0, 0, 4);
        checkOutput("match_held_reset", 0, 1'b0, 0);

        applyStimulus(0, 1, 0, 0, 0, 1);
        applyStimulus(0, 1, 1, 0, 0, 1);
        checkOutput("rearm", 1, 1'b1, 0);
        applyStimulus(0, 1, 0, 0, 0, 25);
        checkOutput("final_idle", 0, 1'b0, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
